// File: rtl/switch_mcu_ahb_arbiter_if.sv
// Bundle of requester handshakes and AHB-Lite master signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/bus view.
interface switch_mcu_ahb_arbiter_if;
   logic        in_init_done;

   logic        in_ifu_req;
   logic [31:0] in_ifu_addr;
   logic        out_ifu_ack;
   logic        out_ifu_err;

   logic        in_lsu_req;
   logic [31:0] in_lsu_addr;
   logic        in_lsu_write;
   logic [3:0]  in_lsu_size;
   logic [31:0] in_lsu_wdata;
   logic        out_lsu_ack;
   logic        out_lsu_err;
   logic [31:0] out_rdata;

   logic        in_hready;
   logic        in_hresp;
   logic [31:0] in_hrdata;
   logic [31:0] out_haddr;
   logic        out_hwrite;
   logic [3:0]  out_hsize;
   logic [3:0]  out_hport;
   logic [2:0]  out_hburst;
   logic [1:0]  out_htrans;
   logic        out_hmastlock;
   logic [31:0] out_hwdata;
   logic        out_owner;

   modport slave (
      input  in_init_done,
      input  in_ifu_req, in_ifu_addr,
      output out_ifu_ack, out_ifu_err,
      input  in_lsu_req, in_lsu_addr, in_lsu_write, in_lsu_size, in_lsu_wdata,
      output out_lsu_ack, out_lsu_err, out_rdata,
      input  in_hready, in_hresp, in_hrdata,
      output out_haddr, out_hwrite, out_hsize, out_hport, out_hburst,
      output out_htrans, out_hmastlock, out_hwdata, out_owner
   );

   modport master (
      output in_init_done,
      output in_ifu_req, in_ifu_addr,
      input  out_ifu_ack, out_ifu_err,
      output in_lsu_req, in_lsu_addr, in_lsu_write, in_lsu_size, in_lsu_wdata,
      input  out_lsu_ack, out_lsu_err, out_rdata,
      output in_hready, in_hresp, in_hrdata,
      input  out_haddr, out_hwrite, out_hsize, out_hport, out_hburst,
      input  out_htrans, out_hmastlock, out_hwdata, out_owner
   );
endinterface

// File: rtl/switch_mcu_ahb_arbiter.sv
// Shares one AHB-Lite master port between the IFU and LSU, one single-beat
// NONSEQ transfer at a time, with an LSU streak limit that protects the IFU.
module switch_mcu_ahb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input logic                  in_clk,
   input logic                  in_rst,
   switch_mcu_ahb_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
   localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
   localparam logic [CNT_W-1:0] LIMIT         = CNT_W'(STARVE_LIMIT);

   state_t            r_state;
   logic [CNT_W-1:0]  r_streak;
   logic              r_owner;
   logic [31:0]       r_haddr;
   logic              r_hwrite;
   logic [3:0]        r_hsize;
   logic [3:0]        r_hprot;
   logic [1:0]        r_htrans;
   logic [31:0]       r_hwdata;
   logic [31:0]       r_wdataLatch;

   logic              w_anyReq;
   logic              w_ifuWins;
   logic              w_grant;
   logic              w_complete;

   assign w_anyReq   = bus.in_ifu_req | bus.in_lsu_req;
   assign w_ifuWins  = bus.in_ifu_req & (~bus.in_lsu_req | (r_streak == LIMIT));
   assign w_grant    = bus.in_init_done & w_anyReq;
   assign w_complete = (r_state == S_DATA) & bus.in_hready;

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         r_state      <= S_IDLE;
         r_streak     <= '0;
         r_owner      <= 1'b0;
         r_haddr      <= '0;
         r_hwrite     <= 1'b0;
         r_hsize      <= '0;
         r_hprot      <= '0;
         r_htrans     <= HTRANS_IDLE;
         r_hwdata     <= '0;
         r_wdataLatch <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_state  <= S_ADDR;
                  r_htrans <= HTRANS_NONSEQ;
                  if (w_ifuWins) begin
                     r_owner  <= 1'b0;
                     r_haddr  <= bus.in_ifu_addr;
                     r_hwrite <= 1'b0;
                     r_hsize  <= 4'd2;
                     r_hprot  <= 4'b0010;
                  end else begin
                     r_owner      <= 1'b1;
                     r_haddr      <= bus.in_lsu_addr;
                     r_hwrite     <= bus.in_lsu_write;
                     r_hsize      <= bus.in_lsu_size;
                     r_hprot      <= 4'b0011;
                     r_wdataLatch <= bus.in_lsu_wdata;
                  end
               end
               // The streak only counts LSU grants taken while the IFU is actually waiting.
               if (!bus.in_ifu_req) begin
                  r_streak <= '0;
               end else if (w_grant) begin
                  if (w_ifuWins) begin
                     r_streak <= '0;
                  end else if (r_streak != LIMIT) begin
                     r_streak <= r_streak + CNT_W'(1);
                  end
               end
            end
            S_ADDR: begin
               if (bus.in_hready) begin
                  r_state  <= S_DATA;
                  r_htrans <= HTRANS_IDLE;
                  if (r_owner && r_hwrite) begin
                     r_hwdata <= r_wdataLatch;
                  end
               end
            end
            S_DATA: begin
               if (bus.in_hready) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_htrans <= HTRANS_IDLE;
            end
         endcase
      end
   end

   // Completion is combinational so the owner sees it in the same cycle HREADY rises.
   assign bus.out_ifu_ack   = w_complete & ~r_owner;
   assign bus.out_ifu_err   = w_complete & ~r_owner & bus.in_hresp;
   assign bus.out_lsu_ack   = w_complete & r_owner;
   assign bus.out_lsu_err   = w_complete & r_owner & bus.in_hresp;
   assign bus.out_rdata     = bus.in_hrdata;

   assign bus.out_haddr     = r_haddr;
   assign bus.out_hwrite    = r_hwrite;
   assign bus.out_hsize     = r_hsize;
   assign bus.out_hport     = r_hprot;
   assign bus.out_hburst    = 3'b000;
   assign bus.out_htrans    = r_htrans;
   assign bus.out_hmastlock = 1'b0;
   assign bus.out_hwdata    = r_hwdata;
   assign bus.out_owner     = r_owner;

endmodule

// File: tb/tb_switch_mcu_ahb_arbiter.sv
// Directed bench: a per-cycle vector table for single transfers, wait states,
// errors and init gating, plus hand sequences for starvation and mid-transfer reset.
module tb_switch_mcu_ahb_arbiter;

   localparam logic [31:0] IA = 32'h0000_0100;
   localparam logic [31:0] LA = 32'h2000_0004;
   localparam logic [31:0] WD = 32'hDEADBEEF;
   localparam int          NV = 18;

   typedef struct {
      logic        rst, init, ifuReq, lsuReq, lsuWrite, hready, hresp;
      logic [31:0] hrdata;
      logic [1:0]  eHtrans;
      logic [31:0] eHaddr;
      logic        eHwrite;
      logic [3:0]  eHsize, eHprot;
      logic [31:0] eHwdata;
      logic        eIfuAck, eIfuErr, eLsuAck, eLsuErr, eOwner;
   } vec_t;

   logic clk;
   logic rst;
   int   nCompared;
   int   nMismatched;
   vec_t vecs [NV];

   switch_mcu_ahb_arbiter_if bus ();

   switch_mcu_ahb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
      .in_clk (clk),
      .in_rst (rst),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compareVal(input string name, input logic [127:0] act, input logic [127:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      rst              = v.rst;
      bus.in_init_done = v.init;
      bus.in_ifu_req   = v.ifuReq;
      bus.in_ifu_addr  = IA;
      bus.in_lsu_req   = v.lsuReq;
      bus.in_lsu_addr  = LA;
      bus.in_lsu_write = v.lsuWrite;
      bus.in_lsu_size  = 4'd2;
      bus.in_lsu_wdata = WD;
      bus.in_hready    = v.hready;
      bus.in_hresp     = v.hresp;
      bus.in_hrdata    = v.hrdata;
   endtask

   task automatic checkOutput(input vec_t v, input int idx);
      logic [127:0] act;
      logic [127:0] exp;
      act = {12'h0, bus.out_htrans, bus.out_haddr, bus.out_hwrite, bus.out_hsize, bus.out_hport,
             bus.out_hburst, bus.out_hmastlock, bus.out_hwdata, bus.out_ifu_ack, bus.out_ifu_err,
             bus.out_lsu_ack, bus.out_lsu_err, bus.out_owner, bus.out_rdata};
      exp = {12'h0, v.eHtrans, v.eHaddr, v.eHwrite, v.eHsize, v.eHprot, 3'b000, 1'b0, v.eHwdata,
             v.eIfuAck, v.eIfuErr, v.eLsuAck, v.eLsuErr, v.eOwner, v.hrdata};
      compareVal($sformatf("vec%0d", idx), act, exp);
   endtask

   initial begin
      bit gotAck;
      bit sawAck;
      nCompared   = 0;
      nMismatched = 0;

      // rst init ifu lsu wr rdy rsp hrdata | htrans haddr hwrite hsize hprot hwdata iack ierr lack lerr owner
      vecs[0]  = '{1, 0, 0, 0, 0, 1, 0, 32'h0,   2'b00, 32'h0, 0, 4'd0, 4'd0, 32'h0, 0, 0, 0, 0, 0};
      vecs[1]  = '{0, 1, 1, 0, 0, 1, 0, 32'h0,   2'b00, 32'h0, 0, 4'd0, 4'd0, 32'h0, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 1, 1, 0, 0, 1, 0, 32'h0,   2'b10, IA,    0, 4'd2, 4'd2, 32'h0, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 1, 1, 0, 0, 1, 0, 32'h13,  2'b00, IA,    0, 4'd2, 4'd2, 32'h0, 1, 0, 0, 0, 0};
      vecs[4]  = '{0, 1, 0, 1, 1, 1, 0, 32'h0,   2'b00, IA,    0, 4'd2, 4'd2, 32'h0, 0, 0, 0, 0, 0};
      vecs[5]  = '{0, 1, 0, 1, 1, 1, 0, 32'h0,   2'b10, LA,    1, 4'd2, 4'd3, 32'h0, 0, 0, 0, 0, 1};
      vecs[6]  = '{0, 1, 0, 1, 1, 0, 0, 32'h0,   2'b00, LA,    1, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[7]  = '{0, 1, 0, 1, 1, 0, 0, 32'h0,   2'b00, LA,    1, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[8]  = '{0, 1, 0, 1, 1, 1, 0, 32'h0,   2'b00, LA,    1, 4'd2, 4'd3, WD,    0, 0, 1, 0, 1};
      vecs[9]  = '{0, 1, 0, 1, 0, 1, 0, 32'h0,   2'b00, LA,    1, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[10] = '{0, 1, 0, 1, 0, 1, 0, 32'h0,   2'b10, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[11] = '{0, 1, 0, 1, 0, 0, 1, 32'h0,   2'b00, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[12] = '{0, 1, 0, 1, 0, 1, 1, 32'hBAD, 2'b00, LA,    0, 4'd2, 4'd3, WD,    0, 0, 1, 1, 1};
      vecs[13] = '{0, 1, 0, 0, 0, 1, 0, 32'h0,   2'b00, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[14] = '{0, 0, 1, 1, 0, 1, 0, 32'h0,   2'b00, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[15] = '{0, 0, 1, 1, 0, 1, 0, 32'h0,   2'b00, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[16] = '{0, 1, 1, 1, 0, 1, 0, 32'h0,   2'b00, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};
      vecs[17] = '{0, 1, 1, 1, 0, 1, 0, 32'h0,   2'b10, LA,    0, 4'd2, 4'd3, WD,    0, 0, 0, 0, 1};

      applyStimulus(vecs[0]);
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(posedge clk);
         #1 applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i], i);
      end

      // Both requesters held continuously: four LSU grants, then the IFU, repeating.
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_init_done = 1'b1;
      bus.in_ifu_req   = 1'b1;
      bus.in_lsu_req   = 1'b1;
      bus.in_lsu_write = 1'b0;
      bus.in_hready    = 1'b1;
      bus.in_hresp     = 1'b0;
      for (int g = 0; g < 10; g++) begin
         gotAck = 1'b0;
         for (int c = 0; c < 8 && !gotAck; c++) begin
            @(negedge clk);
            if (bus.out_ifu_ack || bus.out_lsu_ack) begin
               gotAck = 1'b1;
               compareVal($sformatf("starveGrant%0d", g),
                          {126'h0, bus.out_ifu_ack, bus.out_lsu_ack},
                          (g == 4 || g == 9) ? 128'h2 : 128'h1);
            end
         end
         if (!gotAck) begin
            compareVal($sformatf("starveTimeout%0d", g), 128'h0, 128'h1);
         end
      end

      // Reset while an LSU transfer is stalled in the address phase.
      @(posedge clk);
      #1 rst = 1'b1;
      bus.in_ifu_req = 1'b0;
      bus.in_lsu_req = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_lsu_req   = 1'b1;
      bus.in_lsu_write = 1'b1;
      bus.in_hready    = 1'b0;
      @(posedge clk);
      #1;
      compareVal("rstAddrPhase", {94'h0, bus.out_htrans, bus.out_haddr}, {94'h0, 2'b10, LA});
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_lsu_req = 1'b0;
      bus.in_hready  = 1'b1;
      @(negedge clk);
      compareVal("rstAbandon", {93'h0, bus.out_htrans, bus.out_haddr, bus.out_owner},
                 {93'h0, 2'b00, 32'h0, 1'b0});
      sawAck = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.out_ifu_ack || bus.out_lsu_ack) sawAck = 1'b1;
      end
      compareVal("rstNoAck", {127'h0, sawAck}, 128'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/switch_mcu_ahb_arbiter.md
Name: switch_mcu_ahb_arbiter

Overview:
Shares the core's single AHB-Lite master port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It issues one single-beat NONSEQ transfer at a time and sequences the address and data phases. It returns a one-cycle completion strobe to the owning requester. It sits between switch_mcu_ifu/LSU and the system AHB interconnect, inside switch_mcu_core_top.

Parameters:
STARVE_LIMIT, 4, consecutive LSU grants allowed while the IFU waits; after this count the IFU wins the next arbitration.
CNT_W, 3, width of the LSU streak counter; must hold STARVE_LIMIT.

Ports:
in_clk  input  1  core clock; all logic rising-edge.
in_rst  input  1  synchronous, active-high reset.
in_init_done  input  1  no arbitration while 0.
in_ifu_req  input  1  IFU fetch request; held until in-cycle ack.
in_ifu_addr  input  32  IFU fetch address.
out_ifu_ack  output  1  IFU transfer complete (combinational, one cycle).
out_ifu_err  output  1  qualifies out_ifu_ack; bus error.
in_lsu_req  input  1  LSU request; held with fields stable until ack.
in_lsu_addr  input  32  LSU address.
in_lsu_write  input  1  1 means write.
in_lsu_size  input  4  HSIZE encoding (0=byte, 1=half, 2=word).
in_lsu_wdata  input  32  write data.
out_lsu_ack  output  1  LSU transfer complete.
out_lsu_err  output  1  qualifies out_lsu_ack.
out_rdata  output  32  in_hrdata passthrough; valid with either ack.
in_hready  input  1  AHB HREADY.
in_hresp  input  1  AHB HRESP (1=ERROR).
in_hrdata  input  32  AHB HRDATA.
out_haddr  output  32  AHB HADDR.
out_hwrite  output  1  AHB HWRITE.
out_hsize  output  4  AHB HSIZE.
out_hport  output  4  AHB HPROT.
out_hburst  output  3  always 3'b000 (SINGLE).
out_htrans  output  2  IDLE=2'b00, NONSEQ=2'b10.
out_hmastlock  output  1  always 0.
out_hwdata  output  32  AHB HWDATA.
out_owner  output  1  current or last owner; 0=IFU, 1=LSU.

Behaviour:
- Reset (in_rst=1 at clock edge):
  - State goes to IDLE; the streak counter clears; out_owner=0.
  - All registered bus outputs go to 0: out_htrans=IDLE, out_haddr, out_hwrite, out_hsize, out_hport, out_hwdata.
  - In-flight transfers are abandoned silently; no ack is issued.
  - Reset has priority over every other event.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If in_init_done=1 and any request is pending, the arbiter picks a winner, registers its address/control, and moves to ADDR.
  - out_htrans=NONSEQ in the next cycle.
  - Otherwise the FSM stays in IDLE with out_htrans=IDLE.
- Arbitration (IDLE only):
  - The LSU wins by default.
  - The IFU wins if only the IFU requests, or if both request and streak==STARVE_LIMIT.
  - An LSU grant increments streak, saturating at STARVE_LIMIT.
  - An IFU grant clears streak. Streak also clears on any IDLE cycle with in_ifu_req=0.
- Control per winner:
  - IFU: hwrite=0, hsize=4'd2, hport=4'b0010.
  - LSU: hwrite, hsize, and addr from its inputs; hport=4'b0011.
- ADDR:
  - out_htrans=NONSEQ, with address/control held.
  - On in_hready=1, the FSM moves to DATA. out_htrans becomes IDLE, and out_hwdata is loaded with the latched wdata (LSU writes only; otherwise it holds its old value).
  - If in_hready=0, ADDR and all outputs are held.
- DATA:
  - The FSM waits for in_hready=1. In that cycle the owner's ack=1 and err=in_hresp, out_rdata=in_hrdata, and the next state is IDLE.
  - ERROR response (hresp=1, hready=0 followed by hresp=1, hready=1): no ack in the first cycle; ack with err=1 in the second.
- Throughput and latency:
  - No pipelining of back-to-back transfers; one IDLE bus cycle always separates transfers.
  - Minimum latency is req seen in IDLE at cycle 0, NONSEQ in cycle 1, ack in cycle 2.
- Requester rules:
  - A requester samples ack at the clock edge and must drop or replace req the following cycle.
  - The arbiter does not check field stability.
- Acks are mutually exclusive and never asserted outside DATA.
- in_init_done falling mid-transfer does not abort the transfer; it only blocks new grants.

Test Plan:
- Reset, then init_done=1; IFU req addr 0x0000_0100 with hready=1 always -> htrans=2'b10 with haddr=0x100, hport=4'b0010 in cycle 1; out_ifu_ack=1 in cycle 2 with out_rdata=in_hrdata=0x0000_0013; err=0.
- LSU sw: addr 0x2000_0004, wdata 0xDEADBEEF, size 2, with hready low for 2 cycles in DATA -> hwrite=1, hwdata=0xDEADBEEF from the DATA phase; ack only when hready rises (cycle 4).
- IFU and LSU requesting continuously -> grant sequence LSU,LSU,LSU,LSU,IFU,LSU…; streak resets after the IFU grant.
- LSU read, with the slave giving a two-cycle ERROR (hresp=1, hready 0 then 1) -> no ack in the first cycle; out_lsu_ack=1, out_lsu_err=1 in the second; the FSM returns to IDLE.
- init_done=0 with both requests pending -> htrans stays IDLE and no acks; after init_done rises, the LSU is granted the next cycle.
- in_rst=1 asserted in the ADDR state with hready=0 -> the next cycle shows IDLE, htrans=0, haddr=0, and no ack is ever produced for the abandoned request.
